// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the s0/s1 execution controller:
// instruction fields, opcodes, ALU encodings and FSM states.
package rf_ctrl_pkg;

    localparam int OPC_HI  = 7;
    localparam int OPC_LO  = 5;
    localparam int RD_BIT  = 4;
    localparam int RS2_BIT = 3;
    localparam int IMM_HI  = 2;
    localparam int IMM_LO  = 0;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MOV  = 3'b011;
    localparam logic [2:0] OP_LDI  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_PASS_B = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALTED
    } state_e;

endpackage

// File: rtl/rf_instr_decoder.sv
// Opcode decoder: classifies the latched instruction and
// picks the ALU operation used for register write-back.
module rf_instr_decoder
    import rf_ctrl_pkg::*;
(
    input  logic [2:0] opcode_i,
    output logic [1:0] alu_op_o,
    output logic       writes_reg_o,
    output logic       is_ldi_o,
    output logic       is_halt_o,
    output logic       is_illegal_o
);

    // Non-ALU opcodes leave alu_op at ADD so 2'b11 never appears.
    always_comb begin
        alu_op_o     = ALU_ADD;
        writes_reg_o = 1'b0;
        is_ldi_o     = 1'b0;
        is_halt_o    = 1'b0;
        is_illegal_o = 1'b0;
        unique case (1'b1)
            (opcode_i == OP_NOP): ;
            (opcode_i == OP_ADD): begin
                writes_reg_o = 1'b1;
            end
            (opcode_i == OP_SUB): begin
                alu_op_o     = ALU_SUB;
                writes_reg_o = 1'b1;
            end
            (opcode_i == OP_MOV): begin
                alu_op_o     = ALU_PASS_B;
                writes_reg_o = 1'b1;
            end
            (opcode_i == OP_LDI): begin
                writes_reg_o = 1'b1;
                is_ldi_o     = 1'b1;
            end
            (opcode_i == OP_HALT): begin
                is_halt_o = 1'b1;
            end
            default: begin
                is_illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rf_exec_controller.sv
// Multi-cycle fetch/decode/execute/writeback controller that
// drives the two-entry register file and ALU select lines.
module rf_exec_controller
    import rf_ctrl_pkg::*;
#(
    parameter int PC_W   = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              imem_rd_en,
    output logic [PC_W-1:0]   pc,
    input  logic              instr_valid,
    input  logic [7:0]        instr,
    input  logic [DATA_W-1:0] alu_result,
    output logic [1:0]        alu_op,
    output logic              read_reg1_add,
    output logic              read_reg2_add,
    output logic              write_reg_add,
    output logic [DATA_W-1:0] write_data,
    output logic              write_enable,
    output logic              busy,
    output logic              halted,
    output logic              illegal,
    output logic [7:0]        retired_cnt
);

    state_e            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_d;
    logic [7:0]        ir_q;
    logic [7:0]        ret_q;
    logic [7:0]        ret_d;
    logic              imem_q;
    logic              busy_q;
    logic              halted_q;
    logic              we_q;
    logic              ill_q;
    logic [1:0]        alu_op_q;
    logic              rs1_q;
    logic              rs2_q;
    logic [DATA_W-1:0] wd_q;
    logic [DATA_W-1:0] imm_d;

    logic [1:0] dec_alu_op;
    logic       dec_writes;
    logic       dec_ldi;
    logic       dec_halt;
    logic       dec_ill;

    rf_instr_decoder u_dec (
        .opcode_i     (ir_q[OPC_HI:OPC_LO]),
        .alu_op_o     (dec_alu_op),
        .writes_reg_o (dec_writes),
        .is_ldi_o     (dec_ldi),
        .is_halt_o    (dec_halt),
        .is_illegal_o (dec_ill)
    );

    assign pc_d  = pc_q + 1'b1;
    assign ret_d = ret_q + 8'd1;
    assign imm_d = DATA_W'(ir_q[IMM_HI:IMM_LO]);

    // Main sequencer; every output is a register updated on
    // the transition that enters the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            ret_q    <= '0;
            imem_q   <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            we_q     <= 1'b0;
            ill_q    <= 1'b0;
            alu_op_q <= ALU_ADD;
            rs1_q    <= 1'b0;
            rs2_q    <= 1'b0;
            wd_q     <= '0;
        end else begin
            we_q  <= 1'b0;
            ill_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        state_q  <= S_FETCH;
                        imem_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (instr_valid) begin
                        ir_q    <= instr;
                        pc_q    <= pc_d;
                        imem_q  <= 1'b0;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_op_q <= dec_alu_op;
                    rs1_q    <= ir_q[RD_BIT];
                    rs2_q    <= ir_q[RS2_BIT];
                    state_q  <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    unique case (1'b1)
                        dec_writes: begin
                            wd_q    <= dec_ldi ? imm_d : alu_result;
                            we_q    <= 1'b1;
                            state_q <= S_WRITEBACK;
                        end
                        dec_halt: begin
                            ret_q    <= ret_d;
                            halted_q <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= S_HALTED;
                        end
                        dec_ill: begin
                            ill_q   <= 1'b1;
                            imem_q  <= 1'b1;
                            state_q <= S_FETCH;
                        end
                        default: begin
                            ret_q   <= ret_d;
                            imem_q  <= 1'b1;
                            state_q <= S_FETCH;
                        end
                    endcase
                end
                S_WRITEBACK: begin
                    ret_q   <= ret_d;
                    imem_q  <= 1'b1;
                    state_q <= S_FETCH;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_rd_en    = imem_q;
    assign pc            = pc_q;
    assign alu_op        = alu_op_q;
    assign read_reg1_add = rs1_q;
    assign read_reg2_add = rs2_q;
    assign write_reg_add = rs1_q;
    assign write_data    = wd_q;
    assign write_enable  = we_q & ~rst;
    assign busy          = busy_q;
    assign halted        = halted_q;
    assign illegal       = ill_q;
    assign retired_cnt   = ret_q;

endmodule

// File: tb/tb_rf_exec_controller.sv
// Bench for rf_exec_controller: register file + ALU model
// around the DUT, with an instruction-level reference model.
module tb_rf_exec_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       imem_rd_en;
    logic [3:0] pc;
    logic       instr_valid = 1'b0;
    logic [7:0] instr = 8'h00;
    logic [7:0] alu_result;
    logic [1:0] alu_op;
    logic       read_reg1_add;
    logic       read_reg2_add;
    logic       write_reg_add;
    logic [7:0] write_data;
    logic       write_enable;
    logic       busy;
    logic       halted;
    logic       illegal;
    logic [7:0] retired_cnt;

    rf_exec_controller #(.PC_W(4), .DATA_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .imem_rd_en    (imem_rd_en),
        .pc            (pc),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .alu_result    (alu_result),
        .alu_op        (alu_op),
        .read_reg1_add (read_reg1_add),
        .read_reg2_add (read_reg2_add),
        .write_reg_add (write_reg_add),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .busy          (busy),
        .halted        (halted),
        .illegal       (illegal),
        .retired_cnt   (retired_cnt)
    );

    always #5 clk = ~clk;

    // environment: register file and ALU
    logic [7:0] rf [2];
    logic       tb_wr = 1'b0;
    logic       tb_wa = 1'b0;
    logic [7:0] tb_wd = 8'h00;

    always @(posedge clk) begin
        if (write_enable) rf[write_reg_add] <= write_data;
        else if (tb_wr) rf[tb_wa] <= tb_wd;
    end

    always_comb begin
        case (alu_op)
            2'b00: alu_result = rf[read_reg1_add] + rf[read_reg2_add];
            2'b01: alu_result = rf[read_reg1_add] - rf[read_reg2_add];
            2'b10: alu_result = rf[read_reg2_add];
            default: alu_result = 8'h00;
        endcase
    end

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // reference model: architectural state plus scheduled events
    int         cyc = 0;
    int         t_we = -1, t_fetch = -1, t_ret = -1;
    int         t_halt = -1, t_ill = -1;
    bit         m_fetch = 0, m_busy = 0, m_halted = 0;
    bit         m_we = 0, m_ill = 0;
    logic [3:0] m_pc = 4'd0;
    logic [7:0] m_ret = 8'd0;
    logic [7:0] m_regs [2];
    bit         m_wa = 0;
    logic [7:0] m_wd = 8'h00;

    task automatic step();
        bit acc;
        bit go;
        logic [2:0] op;
        bit rd;
        bit rs;
        @(posedge clk);
        if (m_we && !rst) m_regs[m_wa] = m_wd;
        else if (tb_wr) m_regs[tb_wa] = tb_wd;
        cyc++;
        if (rst) begin
            m_fetch = 0; m_busy = 0; m_halted = 0;
            m_we = 0; m_ill = 0; m_pc = 4'd0; m_ret = 8'd0;
            t_we = -1; t_fetch = -1; t_ret = -1;
            t_halt = -1; t_ill = -1;
        end else begin
            acc = m_fetch && instr_valid;
            go = !m_busy && start;
            if (acc) begin
                m_pc = m_pc + 4'd1;
                op = instr[7:5];
                rd = instr[4];
                rs = instr[3];
                case (op)
                    3'd1, 3'd2, 3'd3, 3'd4: begin
                        m_wa = rd;
                        case (op)
                            3'd1: m_wd = m_regs[rd] + m_regs[rs];
                            3'd2: m_wd = m_regs[rd] - m_regs[rs];
                            3'd3: m_wd = m_regs[rs];
                            default: m_wd = {5'd0, instr[2:0]};
                        endcase
                        t_we = cyc + 2;
                        t_fetch = cyc + 3;
                        t_ret = cyc + 3;
                    end
                    3'd0: begin t_fetch = cyc + 2; t_ret = cyc + 2; end
                    3'd7: begin t_halt = cyc + 2; t_ret = cyc + 2; end
                    default: begin t_ill = cyc + 2; t_fetch = cyc + 2; end
                endcase
            end
            m_fetch = go || (cyc == t_fetch) || (m_fetch && !acc);
            if (go) begin m_busy = 1; m_halted = 0; end
            m_we = (cyc == t_we);
            m_ill = (cyc == t_ill);
            if (cyc == t_ret) m_ret = m_ret + 8'd1;
            if (cyc == t_halt) begin m_halted = 1; m_busy = 0; end
        end
        #1;
    endtask

    // compare DUT against model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_rd_en", imem_rd_en, m_fetch);
            chk("busy", busy, m_busy);
            chk("halted", halted, m_halted);
            chk("pc", pc, m_pc);
            chk("retired_cnt", retired_cnt, m_ret);
            chk("illegal", illegal, m_ill);
            chk("write_enable", write_enable, m_we && !rst);
            if (m_we && !rst) begin
                chk("write_reg_add", write_reg_add, m_wa);
                chk("write_data", write_data, m_wd);
            end
        end
    end

    task automatic set_reg(input bit idx, input logic [7:0] v);
        tb_wr = 1'b1; tb_wa = idx; tb_wd = v;
        step();
        tb_wr = 1'b0;
    endtask

    task automatic issue(input logic [7:0] ins, input int dly);
        int n = 0;
        while (!m_fetch && n < 50) begin
            instr_valid = 1'($urandom);
            instr = 8'($urandom);
            start = m_busy ? 1'($urandom) : 1'b0;
            step();
            n++;
        end
        start = 1'b0;
        instr_valid = 1'b0;
        chk("fetch_reached", m_fetch, 1'b1);
        repeat (dly) step();
        instr = ins;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        instr = 8'($urandom);
    endtask

    task automatic wait_we(input string nm, input bit wa,
                           input logic [7:0] wd, input bit do_alu,
                           input logic [1:0] aop);
        int n = 0;
        while (!write_enable && n < 10) begin step(); n++; end
        chk({nm, "_lat"}, n + 1, 3);
        chk({nm, "_wa"}, write_reg_add, wa);
        chk({nm, "_wd"}, write_data, wd);
        if (do_alu) chk({nm, "_aluop"}, alu_op, aop);
        step();
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (!m_fetch && n < 10) begin step(); n++; end
    endtask

    initial begin
        int n;
        logic [7:0] ins;
        repeat (2) step();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_pc", pc, 0);
        chk("rst_ret", retired_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_imem", imem_rd_en, 0);
        chk("rst_we", write_enable, 0);

        // ADD s0,s1 with s0=4, s1=3
        set_reg(1'b0, 8'd4);
        set_reg(1'b1, 8'd3);
        start = 1'b1; step(); start = 1'b0;
        issue(8'h28, 0);
        wait_we("add", 1'b0, 8'd7, 1'b1, 2'b00);
        chk("add_pc", pc, 1);
        chk("add_ret", retired_cnt, 1);

        // LDI s1,5 then SUB s0,s1 with s0=4
        set_reg(1'b0, 8'd4);
        issue(8'h95, 0);
        wait_we("ldi", 1'b1, 8'h05, 1'b0, 2'b00);
        issue(8'h48, 0);
        wait_we("sub", 1'b0, 8'hFF, 1'b1, 2'b01);
        chk("sub_pc", pc, 3);

        // instr_valid delayed 3 cycles: 0xFF + 5
        issue(8'h28, 3);
        wait_we("delay", 1'b0, 8'h04, 1'b1, 2'b00);
        chk("delay_pc", pc, 4);

        // illegal opcode
        issue(8'hA0, 0);
        n = 0;
        while (!illegal && n < 10) begin step(); n++; end
        chk("ill_lat", n + 1, 3);
        chk("ill_ret", retired_cnt, 4);
        chk("ill_pc", pc, 5);
        chk("ill_imem", imem_rd_en, 1);

        // HALT and resume
        issue(8'hE0, 0);
        n = 0;
        while (!halted && n < 10) begin step(); n++; end
        chk("halt_lat", n + 1, 3);
        chk("halt_busy", busy, 0);
        chk("halt_imem", imem_rd_en, 0);
        chk("halt_ret", retired_cnt, 5);
        step();
        chk("halt_stays", halted, 1);
        start = 1'b1; step(); start = 1'b0;
        chk("resume_pc", pc, 6);
        chk("resume_imem", imem_rd_en, 1);
        issue(8'h00, 0);
        wait_fetch();
        chk("nop_pc", pc, 7);

        // reset during WRITEBACK
        issue(8'h28, 0);
        n = 0;
        while (!m_we && n < 10) begin step(); n++; end
        rst = 1'b1;
        #1;
        chk("rst_wb_we", write_enable, 0);
        step();
        rst = 1'b0;
        chk("rstwb_pc", pc, 0);
        chk("rstwb_ret", retired_cnt, 0);
        chk("rstwb_busy", busy, 0);
        chk("rstwb_rf0", rf[0], 8'h04);

        // 16 NOPs wrap the 4-bit pc
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 16; i++) issue({3'b000, 5'($urandom)}, 0);
        wait_fetch();
        chk("wrap_pc", pc, 0);
        chk("wrap_ret", retired_cnt, 16);

        // randomized program
        for (int i = 0; i < 150; i++) begin
            ins = 8'($urandom);
            issue(ins, $urandom_range(0, 2));
            if (ins[7:5] == 3'b111) begin
                n = 0;
                while (!m_halted && n < 10) begin step(); n++; end
                start = 1'b1; step(); start = 1'b0;
            end
        end
        repeat (6) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
